// File: rtl/pll_seq_ctrl_pkg.sv
// Shared types and constants for the PLL sequencer: state encoding, retry ceiling
// and the helper that sizes the shared cycle counter.
package pll_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        PS_SETUP,
        PS_PULSE,
        PS_GAP
    } state_e;

    localparam int unsigned RETRY_MAX = 15;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter only ever holds values up to N-1, so clog2(N) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned lock_to, input int unsigned stable);
        int unsigned m;
        m = max_u(lock_to, stable);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int unsigned CNT_W = cnt_width(65535, 1024);

endpackage

// File: rtl/pll_seq_ctrl_if.sv
// Phase-shift request/acknowledge bundle between a requester (master) and the
// PLL sequencer (slave).
interface pll_seq_ctrl_if;

    logic       ps_req;
    logic [2:0] ps_sel;
    logic       ps_dir;
    logic [7:0] ps_steps;
    logic       ps_ack;
    logic       ps_err;
    logic       ps_busy;

    modport master (
        output ps_req, ps_sel, ps_dir, ps_steps,
        input  ps_ack, ps_err, ps_busy
    );

    modport slave (
        input  ps_req, ps_sel, ps_dir, ps_steps,
        output ps_ack, ps_err, ps_busy
    );

endinterface

// File: rtl/pll_seq_ctrl_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL LOCK signal; clears to 0 on reset
// so lock is never assumed before it has been sampled.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL power-up/recovery sequencer with phase-shift engine. Define PLL_SEQ_CTRL_PS_EN
// to build the phase-shift states; otherwise every request is rejected with ps_err.
module pll_seq_ctrl
    import pll_seq_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned PSPULSE_W     = 2,
    parameter int unsigned PS_GAP        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [2:0] pll_pssel,
    output logic       pll_psdir,
    output logic       pll_pspulse,
    output logic       pll_ready,
    output logic       sys_reset,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    pll_seq_ctrl_if.slave ps
);

    localparam int unsigned CW = cnt_width(max_u(LOCK_TIMEOUT, RST_CYCLES),
                                           max_u(STABLE_CYCLES, max_u(PSPULSE_W, PS_GAP)));

    logic          lock_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d, retry_inc;
    logic          ack_q, ack_d, err_q, err_d, lost_q, lost_d;
    logic          pll_reset_q, ready_q, sys_reset_q, ready_d;
    logic          in_run_ps, in_ps, ps_d;
`ifdef PLL_SEQ_CTRL_PS_EN
    logic          busy_q, pspulse_q, psdir_q, psdir_d;
    logic [2:0]    pssel_q, pssel_d;
    logic [7:0]    steps_q, steps_d;
`endif

    pll_lock_sync u_lock_sync (
        .clk     (clk),
        .rst     (reset),
        .async_i (pll_lock),
        .sync_o  (lock_s)
    );

    // PS_GAP the identifier is the gap-length parameter; the state needs the package scope.
    assign in_ps     = state_q inside {PS_SETUP, PS_PULSE, pll_seq_ctrl_pkg::PS_GAP};
    assign in_run_ps = in_ps || (state_q == RUN);
    assign retry_inc = (retry_q == 4'(RETRY_MAX)) ? retry_q : retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        lost_d  = 1'b0;
`ifdef PLL_SEQ_CTRL_PS_EN
        steps_d = steps_q;
        pssel_d = pssel_q;
        psdir_d = psdir_q;
`endif
        if (in_run_ps && !lock_s) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = retry_inc;
            lost_d  = 1'b1;
            ack_d   = in_ps;
            err_d   = in_ps;
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        state_d = RST_PLL;
                        cnt_d   = '0;
                        retry_d = retry_inc;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (ps.ps_req) begin
`ifdef PLL_SEQ_CTRL_PS_EN
                        if (ps.ps_steps == '0) begin
                            ack_d = 1'b1;
                        end else begin
                            state_d = PS_SETUP;
                            cnt_d   = '0;
                            steps_d = ps.ps_steps;
                            pssel_d = ps.ps_sel;
                            psdir_d = ps.ps_dir;
                        end
`else
                        ack_d = 1'b1;
                        err_d = 1'b1;
`endif
                    end
                end
`ifdef PLL_SEQ_CTRL_PS_EN
                PS_SETUP: begin
                    state_d = PS_PULSE;
                    cnt_d   = '0;
                end
                PS_PULSE: begin
                    if (cnt_q == CW'(PSPULSE_W - 1)) begin
                        state_d = pll_seq_ctrl_pkg::PS_GAP;
                        cnt_d   = '0;
                        steps_d = steps_q - 8'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                pll_seq_ctrl_pkg::PS_GAP: begin
                    if (cnt_q == CW'(PS_GAP - 1)) begin
                        cnt_d = '0;
                        if (steps_q != '0) begin
                            state_d = PS_PULSE;
                        end else begin
                            state_d = RUN;
                            ack_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
        ps_d    = state_d inside {PS_SETUP, PS_PULSE, pll_seq_ctrl_pkg::PS_GAP};
        ready_d = ps_d || (state_d == RUN);
`ifdef PLL_SEQ_CTRL_PS_EN
        if (!ps_d) begin
            pssel_d = '0;
            psdir_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RST_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            sys_reset_q <= 1'b1;
`ifdef PLL_SEQ_CTRL_PS_EN
            busy_q      <= 1'b0;
            pspulse_q   <= 1'b0;
            pssel_q     <= '0;
            psdir_q     <= 1'b0;
            steps_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
            pll_reset_q <= (state_d == RST_PLL);
            ready_q     <= ready_d;
            sys_reset_q <= ~ready_d;
`ifdef PLL_SEQ_CTRL_PS_EN
            busy_q      <= ps_d;
            pspulse_q   <= (state_d == PS_PULSE);
            pssel_q     <= pssel_d;
            psdir_q     <= psdir_d;
            steps_q     <= steps_d;
`endif
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_ready  = ready_q;
    assign sys_reset  = sys_reset_q;
    assign lock_lost  = lost_q;
    assign retry_cnt  = retry_q;
    assign ps.ps_ack  = ack_q;
    assign ps.ps_err  = err_q;
`ifdef PLL_SEQ_CTRL_PS_EN
    assign ps.ps_busy  = busy_q;
    assign pll_pssel   = pssel_q;
    assign pll_psdir   = psdir_q;
    assign pll_pspulse = pspulse_q;
`else
    assign ps.ps_busy  = 1'b0;
    assign pll_pssel   = '0;
    assign pll_psdir   = 1'b0;
    assign pll_pspulse = 1'b0;
`endif

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl (LOCK_TIMEOUT=100, other parameters default);
// expectations follow PLL_SEQ_CTRL_PS_EN when it is defined for the build.
module tb_pll_seq_ctrl;
    import pll_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset, pll_psdir, pll_pspulse, pll_ready, sys_reset, lock_lost;
    logic [2:0] pll_pssel;
    logic [3:0] retry_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;

    pll_seq_ctrl_if ps_bus ();

    pll_seq_ctrl #(
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_pssel   (pll_pssel),
        .pll_psdir   (pll_psdir),
        .pll_pspulse (pll_pspulse),
        .pll_ready   (pll_ready),
        .sys_reset   (sys_reset),
        .lock_lost   (lock_lost),
        .retry_cnt   (retry_cnt),
        .ps          (ps_bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        pll_lock        = 1'b1;
        ps_bus.ps_req   = 1'b0;
        ps_bus.ps_sel   = 3'd0;
        ps_bus.ps_dir   = 1'b0;
        ps_bus.ps_steps = 8'd0;
        repeat (3) tick;
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_ready", pll_ready, 0);
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_ack", {ps_bus.ps_ack, ps_bus.ps_err, ps_bus.ps_busy}, 0);
        chk("rst_ps_pins", {pll_pssel, pll_psdir, pll_pspulse}, 0);
        reset = 1'b0;

        // Power-up: 16-cycle PLL reset, then ready 16+1+1024 edges after release.
        repeat (15) tick;
        chk("pwr_rst_last", pll_reset, 1);
        tick;
        chk("pwr_rst_off", pll_reset, 0);
        repeat (1040 - 16) tick;
        chk("pwr_ready_early", pll_ready, 0);
        chk("pwr_sysrst_early", sys_reset, 1);
        tick;
        chk("pwr_ready", pll_ready, 1);
        chk("pwr_sys_reset", sys_reset, 0);
        chk("pwr_retry", retry_cnt, 0);

        // Zero-step request answered next cycle.
        ps_bus.ps_req   = 1'b1;
        ps_bus.ps_sel   = 3'd1;
        ps_bus.ps_steps = 8'd0;
        tick;
        chk("zero_ack", ps_bus.ps_ack, 1);
`ifdef PLL_SEQ_CTRL_PS_EN
        chk("zero_err", ps_bus.ps_err, 0);
`else
        chk("zero_err", ps_bus.ps_err, 1);
`endif
        chk("zero_busy", ps_bus.ps_busy, 0);
        ps_bus.ps_req = 1'b0;
        tick;
        chk("zero_ack_clr", ps_bus.ps_ack, 0);

        // Three-step shift, sel=1 dir=0.
        ps_bus.ps_req   = 1'b1;
        ps_bus.ps_sel   = 3'd1;
        ps_bus.ps_dir   = 1'b0;
        ps_bus.ps_steps = 8'd3;
        tick;
`ifdef PLL_SEQ_CTRL_PS_EN
        chk("ps_accept_busy", ps_bus.ps_busy, 1);
        chk("ps_accept_sel", {pll_pssel, pll_psdir}, {3'd1, 1'b0});
        chk("ps_accept_ack", ps_bus.ps_ack, 0);
        ps_bus.ps_req = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            tick;
            chk($sformatf("ps_pulse_%0d", j), pll_pspulse, (((j - 1) % 6) < 2) ? 1 : 0);
            chk($sformatf("ps_sel_%0d", j), {pll_pssel, pll_psdir, ps_bus.ps_ack}, {3'd1, 1'b0, 1'b0});
        end
        tick;
        chk("ps_done_ack", {ps_bus.ps_ack, ps_bus.ps_err, ps_bus.ps_busy}, 3'b100);
        chk("ps_done_pins", {pll_pssel, pll_pspulse}, 0);
        tick;
        chk("ps_done_ack_clr", ps_bus.ps_ack, 0);
`else
        chk("ps_rej_ack", {ps_bus.ps_ack, ps_bus.ps_err, ps_bus.ps_busy}, 3'b110);
        chk("ps_rej_pins", {pll_pssel, pll_psdir, pll_pspulse}, 0);
        ps_bus.ps_req = 1'b0;
        tick;
        chk("ps_rej_ack_clr", ps_bus.ps_ack, 0);
`endif

        // Lock loss (mid step 2 when the shifter is built, plain RUN otherwise).
`ifdef PLL_SEQ_CTRL_PS_EN
        ps_bus.ps_req   = 1'b1;
        ps_bus.ps_sel   = 3'd5;
        ps_bus.ps_dir   = 1'b1;
        ps_bus.ps_steps = 8'd3;
        tick;
        chk("ll_accept", {pll_pssel, pll_psdir, ps_bus.ps_busy}, {3'd5, 1'b1, 1'b1});
        ps_bus.ps_req = 1'b0;
        repeat (5) tick;
        pll_lock = 1'b0;
        repeat (2) tick;
        chk("ll_pulse_before", pll_pspulse, 1);
        chk("ll_lost_before", lock_lost, 0);
        tick;
        chk("ll_pulse_drop", pll_pspulse, 0);
        chk("ll_ack_err", {ps_bus.ps_ack, ps_bus.ps_err, ps_bus.ps_busy}, 3'b110);
        chk("ll_pssel_clr", pll_pssel, 0);
`else
        pll_lock = 1'b0;
        repeat (2) tick;
        chk("ll_lost_before", lock_lost, 0);
        chk("ll_ready_before", pll_ready, 1);
        tick;
`endif
        chk("ll_lost", lock_lost, 1);
        chk("ll_ready", pll_ready, 0);
        chk("ll_sys_reset", sys_reset, 1);
        chk("ll_pll_reset", pll_reset, 1);
        chk("ll_retry", retry_cnt, 1);

        // Lock timeout: 116-cycle retry period; requests ignored outside RUN.
        ps_bus.ps_req   = 1'b1;
        ps_bus.ps_steps = 8'd0;
        for (int k = 1; k <= 116; k++) begin
            tick;
            chk($sformatf("to_pll_reset_%0d", k), pll_reset, (k < 16 || k == 116) ? 1 : 0);
            chk($sformatf("to_no_ack_%0d", k), {ps_bus.ps_ack, lock_lost}, 0);
        end
        chk("to_retry_2", retry_cnt, 2);
        for (int p = 3; p <= 15; p++) begin
            repeat (116) tick;
            chk($sformatf("to_retry_%0d", p), retry_cnt, p);
        end
        repeat (116) tick;
        chk("to_retry_sat", retry_cnt, 15);
        chk("to_sat_reset", pll_reset, 1);
        ps_bus.ps_req = 1'b0;

        // Lock glitch at stable count 500 forces a full recount.
        pll_lock = 1'b1;
        repeat (517) tick;
        pll_lock = 1'b0;
        repeat (3) tick;
        pll_lock = 1'b1;
        repeat (1026) tick;
        chk("gl_ready_early", pll_ready, 0);
        tick;
        chk("gl_ready", pll_ready, 1);
        chk("gl_sys_reset", sys_reset, 0);
        chk("gl_retry", retry_cnt, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_seq_ctrl.md
Name: pll_seq_ctrl

Overview:
- Sequences the board PLL (GW5A PLLA primitive, 50 MHz input) from power-up to a stable, locked state.
- Holds downstream logic in reset until lock has been stable for a programmed time.
- Recovers automatically from lock loss or lock timeout by re-pulsing the PLL reset.
- Services phase-shift requests from a requester via a req/ack handshake, driving the PLL PSSEL/PSDIR/PSPULSE pins.

Parameters:
- RST_CYCLES, 16: width of the PLL reset pulse, in clk cycles (min 1).
- LOCK_TIMEOUT, 65535: clk cycles to wait for lock after reset release before retrying.
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before ready.
- PSPULSE_W, 2: PSPULSE high time per step, in cycles.
- PS_GAP, 4: PSPULSE low time between steps, in cycles.

Ports:
- clk  in  1  free-running 50 MHz board clock (same net as PLL CLKIN).
- reset  in  1  asynchronous, active-high.
- pll_lock  in  1  PLL LOCK, asynchronous to clk.
- pll_reset  out  1  to PLL RESET.
- pll_pssel  out  3  to PLL PSSEL.
- pll_psdir  out  1  to PLL PSDIR.
- pll_pspulse  out  1  to PLL PSPULSE.
- pll_ready  out  1  PLL locked and stable.
- sys_reset  out  1  downstream reset, equal to ~pll_ready, registered.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN or PS states.
- retry_cnt  out  4  saturating count of reset retries.
- ps_req  in  1  phase-shift request, level.
- ps_sel  in  3  output clock to shift.
- ps_dir  in  1  shift direction.
- ps_steps  in  8  number of steps.
- ps_ack  out  1  one-cycle completion pulse.
- ps_err  out  1  valid with ps_ack; 1 means aborted or rejected.
- ps_busy  out  1  request accepted and in progress.

Behaviour:
- Reset values while reset is high:
  - state RST_PLL; pll_reset=1; pll_ready=0; sys_reset=1; all ps_* and pll_ps* outputs 0; lock_lost=0; retry_cnt=0; counters 0.
- pll_lock passes through a 2-flop synchronizer (lock_s), giving 2 cycles of latency. All decisions use lock_s.
- RST_PLL:
  - pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset=0; the timeout counter increments each cycle.
  - lock_s=1: go to STABLE with the stable counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with no lock: go to RST_PLL and increment retry_cnt (saturates at 15).
- STABLE:
  - lock_s=1 counts; after STABLE_CYCLES consecutive cycles go to RUN, with pll_ready=1 and sys_reset=0 registered on the same edge.
  - lock_s=0 at any point: return to WAIT_LOCK with the timeout counter cleared. No retry increment.
- RUN:
  - lock_s=0: lock_lost pulses, then go to RST_PLL and increment retry_cnt. pll_ready falls and sys_reset rises on the same edge.
  - ps_req=1 with ps_steps≠0: latch sel/dir/steps, set ps_busy=1, go to PS_SETUP.
  - ps_req=1 with ps_steps=0: ps_ack=1, ps_err=0 on the next cycle, stay in RUN.
- Phase-shift sequence:
  - PS_SETUP: drive pll_pssel and pll_psdir from the latched values, for 1 cycle, then go to PS_PULSE.
  - PS_PULSE: pll_pspulse=1 for PSPULSE_W cycles, then decrement the step count and go to PS_GAP.
  - PS_GAP: pll_pspulse=0 for PS_GAP cycles. If steps remain, go back to PS_PULSE; otherwise ps_ack=1, ps_err=0, ps_busy=0, return to RUN.
  - pll_pssel and pll_psdir stay stable from PS_SETUP until ack.
- Lock loss in any PS state:
  - Drop pll_pspulse immediately.
  - Pulse lock_lost, then ps_ack=1 with ps_err=1 and ps_busy=0.
  - Go to RST_PLL and increment retry_cnt.
- ps_req is ignored when not in RUN or when ps_busy=1.
- The requester must drop ps_req on ack. If ps_req is still high the cycle after ack, it starts a new request.
- Asserting reset mid-operation aborts immediately to reset values; no ack is generated.

Optional Feature:
- PLL_SEQ_CTRL_PS_EN
  - Defined: the phase-shift engine and the PS_* states are present, as described above.
  - Undefined:
    - pll_pssel, pll_psdir and pll_pspulse are tied to 0; ps_busy is held at 0.
    - Any ps_req in RUN is answered the next cycle with ps_ack=1, ps_err=1.
    - Sequencing and recovery behaviour is unchanged.

Decomposition:
- Package pll_seq_ctrl_pkg holds:
  - the state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, PS_SETUP, PS_PULSE, PS_GAP);
  - the counter-width constant (clog2 of max(LOCK_TIMEOUT, STABLE_CYCLES));
  - RETRY_MAX=15.
- One sub-module: pll_lock_sync, a 2-flop synchronizer with asynchronous-reset-to-0.

Test Plan (defaults unless noted):
1. Power-up: release reset, hold pll_lock=1 throughout. Expect pll_reset high for 16 cycles, then pll_ready=1 and sys_reset=0 at 16+2+1024 cycles ±1, and retry_cnt=0.
2. Lock timeout, with LOCK_TIMEOUT=100: hold pll_lock=0. Expect pll_reset to re-pulse every 116 cycles and retry_cnt to count 1,2,…, saturating at 15.
3. Lock glitch in STABLE: drop pll_lock for 3 cycles at count 500. Expect return to WAIT_LOCK and a full 1024-cycle recount; retry_cnt unchanged.
4. Phase shift: in RUN, request sel=1, dir=0, steps=3. Expect pssel=1 and psdir=0 held throughout, exactly 3 pulses each 2 high / 4 low, then ps_ack with ps_err=0 exactly 1+3×6 cycles after acceptance.
5. Lock loss during shift: drop pll_lock mid-step 2. Expect pspulse to fall, lock_lost and ps_ack with ps_err=1 to pulse, sys_reset=1, retry_cnt=1, and the PLL to re-sequence.
6. Edge requests: ps_steps=0 gives ps_ack with ps_err=0 the next cycle and no pulses; ps_req during WAIT_LOCK is ignored, with no ack.
